// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way write-through cache controller.
package cache_pkg;
  localparam int SETS   = 64;
  localparam int IDX_W  = 6;
  localparam int TAG_W  = 10;
  localparam int LINE_W = 64;
  localparam logic [31:0] MEM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } state_e;

  // Pick the 32-bit word of a line; off=1 is the upper word.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic off);
    return off ? line[63:32] : line[31:0];
  endfunction
endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data arrays, async read, single sync write port.
module cache_way
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_data,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic              i_wr_valid,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_data
);
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];

  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else if (i_we) r_valid[i_wr_idx] <= i_wr_valid;
  end

  // A write with i_wr_valid=0 is an invalidate and leaves tag/data untouched.
  always_ff @(posedge clk) begin
    if (i_we && i_wr_valid) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];
endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate cache in front of an SRAM controller.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic [1:0]  o_dbg_state
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_RD_MISS = ST_RD_MISS;
  localparam logic [1:0] S_WR_THRU = ST_WR_THRU;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_off;
  logic [SETS-1:0]  r_lru;

  logic [31:0]       w_ea;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_off;
  logic              w_unused_ea;
  logic              w_idle, w_store, w_load, w_rd_hit, w_fill, w_fill_way;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [1:0]        w_valid, w_hit, w_we;
  logic              w_hit_any, w_hit_way;
  logic [TAG_W-1:0]  w_way_tag  [2];
  logic [LINE_W-1:0] w_way_data [2];

  assign w_ea        = address - MEM_BASE;
  assign w_idx       = w_ea[8:3];
  assign w_tag       = w_ea[18:9];
  assign w_off       = w_ea[2];
  assign w_unused_ea = ^{w_ea[31:19], w_ea[1:0]};

  assign w_idle   = (r_state == S_IDLE);
  assign w_rd_idx = w_idle ? w_idx : r_idx;
  assign w_store  = w_idle & mem_w_en;
  assign w_load   = w_idle & mem_r_en & ~mem_w_en;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_way
      assign w_hit[g] = w_valid[g] && (w_way_tag[g] == w_tag);
      // Stores invalidate on entry; fills land in the chosen victim way.
      assign w_we[g]  = ~rst & ((w_store & w_hit[g]) | (w_fill & (w_fill_way == 1'(g))));
      cache_way u_way (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_rd_idx),
        .o_valid    (w_valid[g]),
        .o_tag      (w_way_tag[g]),
        .o_data     (w_way_data[g]),
        .i_we       (w_we[g]),
        .i_wr_idx   (w_rd_idx),
        .i_wr_valid (w_fill),
        .i_wr_tag   (r_tag),
        .i_wr_data  (sram_rdata)
      );
    end
  endgenerate

  assign w_hit_any  = |w_hit;
  assign w_hit_way  = w_hit[1];
  assign w_rd_hit   = w_load & w_hit_any;
  assign w_fill     = (r_state == S_RD_MISS) & sram_ready;
  assign w_fill_way = (~w_valid[0] & ~w_valid[1]) ? 1'b0 : r_lru[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lru   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_store) r_state <= S_WR_THRU;
          else if (w_load && !w_hit_any) r_state <= S_RD_MISS;
          if (w_rd_hit) r_lru[w_idx] <= ~w_hit_way;
        end
        S_RD_MISS: begin
          if (sram_ready) begin
            r_state      <= S_IDLE;
            r_lru[r_idx] <= ~r_lru[r_idx];
          end
        end
        S_WR_THRU: if (sram_ready) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Request fields are captured every idle cycle so they are held once we leave IDLE.
  always_ff @(posedge clk) begin
    if (w_idle) begin
      r_idx <= w_idx;
      r_tag <= w_tag;
      r_off <= w_off;
    end
  end

  always_comb begin
    ready     = 1'b1;
    rdata     = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_store || (w_load && !w_hit_any)) ready = 1'b0;
          else if (w_rd_hit) rdata = line_word(w_way_data[w_hit_way], w_off);
        end
        S_RD_MISS: begin
          sram_r_en = 1'b1;
          ready     = sram_ready;
          if (sram_ready) rdata = line_word(sram_rdata, r_off);
        end
        S_WR_THRU: begin
          sram_w_en = 1'b1;
          ready     = sram_ready;
        end
        default: ready = 1'b1;
      endcase
    end
  end

  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign o_dbg_state  = r_state;

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_rd_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_fill && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif
endmodule
